// File: rtl/mem_strobe_sequencer.sv
// -----------------------------------------------------------------------------
// mem_strobe_sequencer
//   Sits behind the addr[31:30] chip-select decoder and runs one bus request at
//   a time against an asynchronous-style memory/IO device. The request and the
//   decoder selects are captured at acceptance; the block then drives the chosen
//   active-low chip enable plus the OE_n/WE_n strobe with programmable setup,
//   wait and hold timing, and returns a single-cycle response.
//
//   Every output is a register. Strobe/enable/response registers are loaded
//   from the current state, so pin activity trails the state by one cycle;
//   req_ready is loaded on the same edge as the state it reflects.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_we, req_addr, req_wdata   request direction, address, write data
//   memce0, memce1, cs            decoder selects (active-high, sampled at accept)
//   mem_ce0_n, mem_ce1_n, io_cs_n chip enables (active-low)
//   mem_oe_n, mem_we_n            read / write strobes (active-low)
//   mem_addr, mem_wdata           registered address [29:0] and write data
//   mem_rdata                     device read data
//   rsp_valid, rsp_rdata, rsp_err one-cycle response, read data, select error
// -----------------------------------------------------------------------------
module mem_strobe_sequencer #(
  parameter int DW        = 32,
  parameter int SETUP_CYC = 1,
  parameter int WAIT_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic          memce0,
  input  logic          memce1,
  input  logic          cs,
  output logic          mem_ce0_n,
  output logic          mem_ce1_n,
  output logic          io_cs_n,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  output logic [29:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  localparam int MAX_CYC = (SETUP_CYC > WAIT_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((WAIT_CYC  > HOLD_CYC) ? WAIT_CYC  : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, HOLD, RESP, ERR
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [2:0]      sel_q;      // {cs, memce1, memce0}, one-hot when valid
  logic [29:0]     addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            ready_q;
  logic            ce0_n_q, ce1_n_q, io_n_q, oe_n_q, we_n_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [DW-1:0]   rsp_rdata_q;

  // Address bits [31:30] belong to the upstream decoder only.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:30];

  // NOTE: === makes an X/Z select count as "not selected"; synthesis treats it as ==.
  logic [2:0] sel_in;
  logic       sel_ok;
  logic       in_xfer;
  assign sel_in  = {cs === 1'b1, memce1 === 1'b1, memce0 === 1'b1};
  assign sel_ok  = (sel_in == 3'b001) || (sel_in == 3'b010) || (sel_in == 3'b100);
  assign in_xfer = (state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // below sees the pre-edge value of every other register regardless of order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      ce0_n_q     <= 1'b1;
      ce1_n_q     <= 1'b1;
      io_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // Pin registers follow the current state; the selected CE is the only
      // one that can fall, and strobes only fall inside the CE window.
      ce0_n_q     <= !(in_xfer && sel_q[0]);
      ce1_n_q     <= !(in_xfer && sel_q[1]);
      io_n_q      <= !(in_xfer && sel_q[2]);
      oe_n_q      <= !((state_q == ACCESS) && !we_q);
      we_n_q      <= !((state_q == ACCESS) &&  we_q);
      rsp_valid_q <= (state_q == RESP) || (state_q == ERR);
      rsp_err_q   <= (state_q == ERR);
      rsp_rdata_q <= ((state_q == RESP) && !we_q) ? rdata_q : '0;

      unique case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            we_q    <= req_we;
            sel_q   <= sel_in;
            addr_q  <= req_addr[29:0];
            wdata_q <= req_wdata;
            ready_q <= 1'b0;
            cnt_q   <= CW'(SETUP_CYC - 1);
            state_q <= sel_ok ? SETUP : ERR;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            cnt_q   <= CW'(WAIT_CYC - 1);
            state_q <= ACCESS;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            if (!we_q) rdata_q <= mem_rdata;
            cnt_q   <= CW'(HOLD_CYC - 1);
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        RESP, ERR: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign mem_ce0_n = ce0_n_q;
  assign mem_ce1_n = ce1_n_q;
  assign io_cs_n   = io_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_strobe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_strobe_sequencer
//   Drives two instances in parallel: A with default timing (1/2/1) and B with
//   2/3/2. Both see the same request and device inputs. Expected pin behaviour
//   for each cycle after the transfer edge is computed from the latency rules:
//   CE low for cycles 1..L (L = setup+wait+hold), strobe low for cycles
//   setup+1..setup+wait, response in cycle L+1, ready from cycle L+1 on; a bad
//   select responds in cycle 1. With req_valid held, the pattern repeats every
//   L+2 (or 2) cycles.
// -----------------------------------------------------------------------------
module tb_mem_strobe_sequencer;

  localparam int DW = 32;
  localparam int SA = 1, WA = 2, HA = 1;
  localparam int SB = 2, WB = 3, HB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata, mem_rdata;
  logic          memce0, memce1, cs;

  logic          ready_a, ce0_a, ce1_a, io_a, oe_a, we_a, rv_a, re_a;
  logic [29:0]   maddr_a;
  logic [DW-1:0] mwdata_a, rrdata_a;
  logic          ready_b, ce0_b, ce1_b, io_b, oe_b, we_b, rv_b, re_b;
  logic [29:0]   maddr_b;
  logic [DW-1:0] mwdata_b, rrdata_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_strobe_sequencer #(.DW(DW), .SETUP_CYC(SA), .WAIT_CYC(WA), .HOLD_CYC(HA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .memce0(memce0), .memce1(memce1), .cs(cs),
    .mem_ce0_n(ce0_a), .mem_ce1_n(ce1_a), .io_cs_n(io_a),
    .mem_oe_n(oe_a), .mem_we_n(we_a), .mem_addr(maddr_a), .mem_wdata(mwdata_a),
    .mem_rdata(mem_rdata), .rsp_valid(rv_a), .rsp_rdata(rrdata_a), .rsp_err(re_a)
  );

  mem_strobe_sequencer #(.DW(DW), .SETUP_CYC(SB), .WAIT_CYC(WB), .HOLD_CYC(HB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .memce0(memce0), .memce1(memce1), .cs(cs),
    .mem_ce0_n(ce0_b), .mem_ce1_n(ce1_b), .io_cs_n(io_b),
    .mem_oe_n(oe_b), .mem_we_n(we_b), .mem_addr(maddr_b), .mem_wdata(mwdata_b),
    .mem_rdata(mem_rdata), .rsp_valid(rv_b), .rsp_rdata(rrdata_b), .rsp_err(re_b)
  );

  // Control pins packed as {ce0_n, ce1_n, io_cs_n, oe_n, we_n, ready, rsp_valid, rsp_err}
  logic [7:0] ctrl_a, ctrl_b;
  assign ctrl_a = {ce0_a, ce1_a, io_a, oe_a, we_a, ready_a, rv_a, re_a};
  assign ctrl_b = {ce0_b, ce1_b, io_b, oe_b, we_b, ready_b, rv_b, re_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: expected control pins in the cycle following edge k of a transfer.
  function automatic logic [7:0] model_ctrl(input int k, input int s, input int w, input int h,
                                            input bit ok, input bit we, input bit [2:0] sel);
    int  l = s + w + h;
    bit  ce, stb, rdy, rsp;
    if (ok) begin
      ce  = (k >= 1) && (k <= l);
      stb = (k >= s + 1) && (k <= s + w);
      rdy = (k >= l + 1);
      rsp = (k == l + 1);
    end else begin
      ce  = 1'b0;
      stb = 1'b0;
      rdy = (k >= 1);
      rsp = (k == 1);
    end
    return {!(ce && sel[0]), !(ce && sel[1]), !(ce && sel[2]),
            !(stb && !we), !(stb && we), rdy, rsp, rsp && !ok};
  endfunction

  task automatic check_dut(input string name, input int k, input int s, input int w, input int h,
                           input bit held, input bit ok, input bit we, input bit [2:0] sel,
                           input logic [31:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input logic [7:0] ctrl,
                           input logic [29:0] maddr, input logic [DW-1:0] mwdata,
                           input logic [DW-1:0] rrdata);
    int period = ok ? (s + w + h + 2) : 2;
    int ph     = held ? (k % period) : k;
    logic [7:0] exp = model_ctrl(ph, s, w, h, ok, we, sel);
    check($sformatf("%s ctrl k=%0d", name, k), {24'd0, ctrl}, {24'd0, exp});
    check($sformatf("%s mem_addr k=%0d", name, k), {2'b00, maddr}, {2'b00, addr[29:0]});
    check($sformatf("%s mem_wdata k=%0d", name, k), mwdata, wdata);
    if (exp[1])
      check($sformatf("%s rsp_rdata k=%0d", name, k), rrdata, (ok && !we) ? rdata : '0);
  endtask

  // One request presented to both instances. held=1 keeps req_valid asserted
  // with the same request so back-to-back acceptance is exercised.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input logic m0, input logic m1,
                         input logic c, input bit held);
    bit [2:0] sel;
    bit       ok;
    int       pa, pb, ncyc, guard;
    sel = {c === 1'b1, m1 === 1'b1, m0 === 1'b1};
    ok  = ($countones(sel) == 1);
    pa  = ok ? (SA + WA + HA + 2) : 2;
    pb  = ok ? (SB + WB + HB + 2) : 2;
    ncyc = (pa > pb) ? pa : pb;
    if (held) ncyc = 3 * ncyc;

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    mem_rdata = rdata; memce0 = m0; memce1 = m1; cs = c;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_dut("A", k, SA, WA, HA, held, ok, we, sel, addr, wdata, rdata,
                ctrl_a, maddr_a, mwdata_a, rrdata_a);
      check_dut("B", k, SB, WB, HB, held, ok, we, sel, addr, wdata, rdata,
                ctrl_b, maddr_b, mwdata_b, rrdata_b);
      if (k == 0 && !held) begin
        // Request and selects are don't-care once captured.
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
        memce0 = 1'($urandom); memce1 = 1'($urandom); cs = 1'($urandom);
      end
    end
    req_valid = 1'b0;
    guard = 0;
    while (!(ready_a && ready_b) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("idle timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " ctrl A"}, {24'd0, ctrl_a}, 32'h0000_00fc);
    check({tag, " ctrl B"}, {24'd0, ctrl_b}, 32'h0000_00fc);
    check({tag, " mem_addr A"}, {2'b00, maddr_a}, 32'd0);
    check({tag, " mem_wdata A"}, mwdata_a, 32'd0);
    check({tag, " rsp_rdata A"}, rrdata_a, 32'd0);
    check({tag, " mem_addr B"}, {2'b00, maddr_b}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; memce0 = 1'b0; memce1 = 1'b0; cs = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Directed cases
    run_txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h4000_0004, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 1'b0);
    run_txn(1'b0, 32'h8000_0020, 32'h0, 32'h1111_2222, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_txn(1'b0, 32'hC000_0040, 32'h0, 32'h3333_4444, 1'b1, 1'b1, 1'bx, 1'b0);
    run_txn(1'b0, 32'hC000_0100, 32'h0, 32'h5555_6666, 1'b0, 1'b0, 1'b1, 1'b1);
    run_txn(1'b0, 32'h0000_0200, 32'h0, 32'h7777_8888, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during the write strobe of instance A: no response may follow.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0044; req_wdata = 32'h0BAD_CAFE;
    memce0 = 1'b1; memce1 = 1'b0; cs = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("abort A we_n low", {31'd0, we_a}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check_reset_state("abort");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("abort no rsp A %0d", i), {31'd0, rv_a}, 32'd0);
      check($sformatf("abort no rsp B %0d", i), {31'd0, rv_b}, 32'd0);
      check($sformatf("abort ready A %0d", i), {31'd0, ready_a}, 32'd1);
    end

    // Randomized requests, mostly valid selects, sometimes held back-to-back.
    for (int t = 0; t < 40; t++) begin
      logic [2:0] s3;
      if ($urandom_range(0, 9) < 7) s3 = 3'b001 << $urandom_range(0, 2);
      else                          s3 = 3'($urandom);
      run_txn(1'($urandom), $urandom, $urandom, $urandom, s3[0], s3[1], s3[2],
              $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
